// File: rtl/alu_seq_pkg.sv
// Shared opcodes and controller state encoding for the sequential ALU/register-file block.
package alu_seq_pkg;

    localparam logic [2:0] OP_INC   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_ORXOR = 3'b011;
    localparam logic [2:0] OP_ANY   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SHR   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

endpackage

// File: rtl/alu_seq_mul_unit.sv
// Shift-add multiplier: WIDTH iterations after load; done flags the final iteration
// cycle and product presents the completed value that lands on that same edge.
module seq_mul_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             last_iter;

    assign last_iter = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (load) begin
            mcand_d  = PW'(b);
            mplier_d = a;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Multiplier is consumed LSB first while the multiplicand walks left.
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last_iter) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = last_iter;
    assign product = prod_d;

endmodule

// File: rtl/alu_seq_regfile.sv
// ALU with NREGS result registers: single-cycle ops write on the accepting edge,
// multiply runs WIDTH cycles; start is dropped (not queued) while busy.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NREGS = 4,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           func,
    input  logic [WIDTH-1:0]     a,
    input  logic [RW-1:0]        rs,
    input  logic [RW-1:0]        rd,
    input  logic [RW-1:0]        view_sel,
    output logic [2*WIDTH-1:0]   view_data,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    regs_q [NREGS];
    logic [PW-1:0]    regs_d [NREGS];
    state_t           state_q, state_d;
    logic [PW-1:0]    result_q, result_d;
    logic             done_q, done_d;
    logic [RW-1:0]    rd_q, rd_d;

    logic [WIDTH-1:0] b_op;
    logic [PW-1:0]    a_ext, b_ext, alu_val;
    logic             mul_load, mul_busy, mul_done;
    logic [PW-1:0]    mul_prod;
    logic             wr_en;
    logic [RW-1:0]    wr_idx;
    logic [PW-1:0]    wr_val;

    assign b_op  = regs_q[rs][WIDTH-1:0];
    assign a_ext = PW'(a);
    assign b_ext = PW'(b_op);

    always_comb begin
        alu_val = '0;
        case (func)
            OP_INC:   alu_val = a_ext + 1'b1;
            OP_ADD:   alu_val = a_ext + b_ext;
            OP_SUB:   alu_val = a_ext - b_ext;
            OP_ORXOR: alu_val = {a | b_op, a ^ b_op};
            OP_ANY:   alu_val = PW'((a | b_op) != '0);
            OP_SHL:   alu_val = (int'(a) >= PW) ? '0 : (b_ext << a);
            OP_SHR:   alu_val = b_ext >> a;
            default:  alu_val = '0;
        endcase
    end

    seq_mul_unit #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .load    (mul_load),
        .a       (a),
        .b       (b_op),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        rd_d     = rd_q;
        mul_load = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = rd;
        wr_val   = alu_val;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (func != OP_MUL) begin
                        wr_en  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        mul_load = 1'b1;
                        rd_d     = rd;
                        state_d  = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    wr_en   = 1'b1;
                    wr_idx  = rd_q;
                    wr_val  = mul_prod;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        regs_d   = regs_q;
        result_d = result_q;
        if (wr_en) begin
            regs_d[wr_idx] = wr_val;
            result_d       = wr_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            rd_q     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            regs_q   <= regs_d;
        end
    end

    assign view_data = regs_q[view_sel];
    assign result    = result_q;
    assign busy      = mul_busy;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_seq_regfile.sv
// Directed bench for alu_seq_regfile (WIDTH=4, NREGS=4); expected results are queued
// at issue time and popped by a monitor on every done cycle.
module tb_alu_seq_regfile;

    localparam logic [2:0] F_INC   = 3'b000;
    localparam logic [2:0] F_ADD   = 3'b001;
    localparam logic [2:0] F_SUB   = 3'b010;
    localparam logic [2:0] F_ORXOR = 3'b011;
    localparam logic [2:0] F_ANY   = 3'b100;
    localparam logic [2:0] F_SHL   = 3'b101;
    localparam logic [2:0] F_SHR   = 3'b110;
    localparam logic [2:0] F_MUL   = 3'b111;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] func;
    logic [3:0] a;
    logic [1:0] rs, rd, view_sel;
    logic [7:0] view_data, result;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    alu_seq_regfile #(.WIDTH(4), .NREGS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .func      (func),
        .a         (a),
        .rs        (rs),
        .rd        (rd),
        .view_sel  (view_sel),
        .view_data (view_data),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done cycle corresponds to exactly one queued write.
    initial begin
        forever begin
            @(negedge clock);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("result", result, exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [3:0] av, input logic [1:0] s,
                         input logic [1:0] d, input logic push, input logic [7:0] e);
        @(negedge clock);
        func  = f;
        a     = av;
        rs    = s;
        rd    = d;
        start = 1'b1;
        if (push) exp_q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_reg(input int idx, input logic [7:0] e);
        view_sel = 2'(idx);
        #1;
        chk($sformatf("reg%0d", idx), view_data, e);
    endtask

    task automatic mul_run(input logic [3:0] av, input logic [1:0] s, input logic [1:0] d,
                           input logic [7:0] e, input logic spam);
        int n;
        issue(F_MUL, av, s, d, 1'b1, e);
        @(negedge clock);
        if (spam) begin
            start = 1'b1;
            func  = F_ADD;
            a     = 4'hF;
            rs    = 2'd0;
            rd    = 2'd0;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clock);
        end
        start = 1'b0;
        chk("mul_busy_cycles", n, 4);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        func     = '0;
        a        = '0;
        rs       = '0;
        rd       = '0;
        view_sel = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) check_reg(i, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 8'h00);

        // INC with carry into bit WIDTH
        issue(F_INC, 4'hF, 2'd0, 2'd1, 1'b1, 8'h10);
        idle();
        chk("inc_done", done, 1);
        check_reg(1, 8'h10);

        // Multiply, with start spam during busy
        issue(F_ADD, 4'h5, 2'd0, 2'd2, 1'b1, 8'h05);
        idle();
        check_reg(2, 8'h05);
        mul_run(4'h3, 2'd2, 2'd3, 8'h0F, 1'b1);
        check_reg(0, 8'h00);
        check_reg(2, 8'h05);
        check_reg(3, 8'h0F);
        mul_run(4'hF, 2'd3, 2'd3, 8'hE1, 1'b0);
        check_reg(3, 8'hE1);

        // Back-to-back shifts on reg2=0x05
        issue(F_SHL, 4'd2, 2'd2, 2'd1, 1'b1, 8'h14);
        issue(F_SHL, 4'd9, 2'd2, 2'd1, 1'b1, 8'h00);
        issue(F_SHL, 4'd7, 2'd2, 2'd1, 1'b1, 8'h80);
        issue(F_SHR, 4'd1, 2'd2, 2'd1, 1'b1, 8'h02);
        idle();
        check_reg(1, 8'h02);

        // SUB with rs==rd reads the old value
        issue(F_SUB, 4'h3, 2'd2, 2'd2, 1'b1, 8'hFE);
        idle();
        check_reg(2, 8'hFE);
        issue(F_ORXOR, 4'hA, 2'd0, 2'd1, 1'b1, 8'hAA);
        idle();
        check_reg(1, 8'hAA);
        issue(F_ANY, 4'h0, 2'd0, 2'd1, 1'b1, 8'h00);
        issue(F_ANY, 4'h0, 2'd2, 2'd0, 1'b1, 8'h01);
        idle();
        check_reg(1, 8'h00);
        check_reg(0, 8'h01);

        // Abort: reset sampled at the end of the 2nd MUL cycle
        issue(F_MUL, 4'h3, 2'd2, 2'd3, 1'b0, 8'h00);
        idle();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 8'h00);
        for (int i = 0; i < 4; i++) check_reg(i, 8'h00);
        repeat (6) @(negedge clock);

        // Normal operation after abort
        issue(F_ADD, 4'h7, 2'd0, 2'd1, 1'b1, 8'h07);
        idle();
        mul_run(4'h2, 2'd1, 2'd2, 8'h0E, 1'b0);
        check_reg(2, 8'h0E);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_regfile.md
# alu_seq_regfile

Parametrised successor to the board-level ALU-plus-accumulator datapath. It holds NREGS result registers of 2·WIDTH bits and executes one ALU operation per start pulse. Operand A comes from switches and operand B is read from a selectable register. Most ops complete in one cycle; multiply is a multi-cycle shift-add with a busy/done handshake. It sits between switch/key input logic and the LEDR/HEX display decoders.

## Interface
- WIDTH, 4: operand width; results are 2·WIDTH bits.
- NREGS, 4: number of result registers; power of two, ≥2.
- RW, $clog2(NREGS): register index width (derived, not overridden).

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  request an op; sampled only when busy=0.
- func  in  3  opcode.
- a  in  WIDTH  operand A.
- rs  in  RW  source register; B = reg[rs][WIDTH-1:0].
- rd  in  RW  destination register.
- view_sel  in  RW  display read select.
- view_data  out  2·WIDTH  combinational reg[view_sel].
- result  out  2·WIDTH  last written value; holds until next write.
- busy  out  1  high while multiply in progress.
- done  out  1  one-cycle pulse, the cycle after a register write.

## Operation
- One clock, named clock. Reset is synchronous and active-high, named reset.
- Opcodes; all operands are zero-extended to 2·WIDTH:
  - 000: A+1, carry lands in bit WIDTH.
  - 001: A+B, carry lands in bit WIDTH.
  - 010: A−B mod 2^(2·WIDTH), two's complement.
  - 011: {A|B, A^B}.
  - 100: 1 if (A|B)≠0, else 0.
  - 101: B << A. If A ≥ 2·WIDTH, the result is 0.
  - 110: B >> A (logical).
  - 111: A·B, computed by a multi-cycle shift-add.
- FSM states:
  - IDLE:
    - start with func≠111: compute, write reg[rd] and result, pulse done; stay in IDLE.
    - start with func=111: latch A, B and rd; clear the product and the counter; go to MUL.
  - MUL: busy=1. Each cycle, add the shifted multiplicand if the current multiplier bit is 1. After WIDTH iterations, write reg[rd] and result, pulse done, return to IDLE.
- B is read at the accepting edge, so rs==rd uses the pre-write value.
- Operands and rd are captured at acceptance. Input changes during MUL have no effect.
- start while busy=1 is ignored. It is not queued.

## Timing
- Reset values: all regs 0; result 0; busy 0; done 0; state IDLE.
- Single-cycle op accepted at edge k:
  - reg[rd] and result update at edge k.
  - done=1 from edge k to edge k+1.
  - view_data reflects the new value after edge k.
- Single-cycle ops can be issued back-to-back, one per cycle; done stays high continuously.
- Multiply accepted at edge k:
  - busy=1 from k to k+WIDTH.
  - Write and done at edge k+WIDTH.
  - Total latency is WIDTH cycles.
  - A start sampled at edge k+WIDTH is ignored. The next start is accepted at edge k+WIDTH+1.
- Reset during MUL: the op is aborted with no write, and all outputs take their reset values at that edge.
- Reset has priority over start in the same cycle.

## Structure
- Package alu_seq_pkg holds:
  - the func localparams (OP_INC, OP_ADD, OP_SUB, OP_ORXOR, OP_ANY, OP_SHL, OP_SHR, OP_MUL);
  - the state enum (S_IDLE, S_MUL).
- One sub-module, seq_mul_unit: a shift-add multiplier with load/busy/done, parametrised by WIDTH.
- The register file and the single-cycle datapath stay in the top module.
- The existing hex decoder is instantiated outside this block.

## Test plan
All scenarios use WIDTH=4, NREGS=4.
- Reset: view every reg = 0x00, busy=0, done=0, result=0x00.
- INC carry: start, func=000, a=F, rd=1 → next cycle done=1, result=0x10, reg1=0x10.
- Multiply: ADD a=5, rs=0, rd=2 gives reg2=0x05. Then MUL a=3, rs=2, rd=3 → busy high for 4 cycles, done in cycle 4, reg3=0x0F. Extra start pulses during busy do not alter any reg. Also check MUL a=F with reg=0x0F → 0xE1.
- Shifts with reg2=0x05, rs=2:
  - SHL a=2 → 0x14.
  - SHL a=9 → 0x00.
  - SHR a=1 → 0x02.
- SUB and rs==rd: SUB a=3, rs=2, rd=2 → reg2=0xFE (old B used). Then ORXOR a=A, rs=0 → 0xAA. ANY a=0, rs=0 → 0x01 only if reg0 nonzero, else 0x00.
- Abort: reset asserted in the 2nd MUL cycle → busy=0, done never pulses, all regs 0x00. A new start two cycles later executes normally.
